// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester A/B handshakes plus the memory command/response bus of the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = dmem_arb_pkg::DEF_DATA_W
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              stall;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  stall,
    input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
    output mem_read_data
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output stall,
    output mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
    input  mem_read_data
  );
endinterface

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive denied cycles for the low-priority requester.
module dmem_starve_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       gnt,
    input  logic [3:0] limit,
    output logic       expired
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || gnt || !req) begin
            cnt <= '0;
        end else if (cnt != limit) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory: A has priority,
// B is guaranteed service after MAX_WAIT consecutive denials.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic              a_win;
    logic              b_win;
    logic              b_expired;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              we_mux;
    logic              rd_mux;
    owner_t            resp_own;
    owner_t            resp_own_d;

    dmem_starve_cnt u_starve (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.b_req),
        .gnt    (b_win),
        .limit  (LIMIT),
        .expired(b_expired)
    );

    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (!reset) begin
            if (bus.b_req && (!bus.a_req || b_expired)) begin
                b_win = 1'b1;
            end else if (bus.a_req) begin
                a_win = 1'b1;
            end
        end
    end

    always_comb begin
        addr_mux   = '0;
        wdata_mux  = '0;
        we_mux     = 1'b0;
        rd_mux     = 1'b0;
        resp_own_d = OWN_NONE;
        if (b_win) begin
            addr_mux   = bus.b_addr;
            wdata_mux  = bus.b_wdata;
            we_mux     = bus.b_we;
            rd_mux     = !bus.b_we;
            resp_own_d = bus.b_we ? OWN_NONE : OWN_B;
        end else if (a_win) begin
            addr_mux   = bus.a_addr;
            wdata_mux  = bus.a_wdata;
            we_mux     = bus.a_we;
            rd_mux     = !bus.a_we;
            resp_own_d = bus.a_we ? OWN_NONE : OWN_A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_own <= OWN_NONE;
        end else begin
            resp_own <= resp_own_d;
        end
    end

    assign bus.a_gnt          = a_win;
    assign bus.b_gnt          = b_win;
    assign bus.stall          = bus.a_req && !a_win;
    assign bus.mem_address    = addr_mux;
    assign bus.mem_write_data = wdata_mux;
    assign bus.mem_MemWrite   = we_mux;
    assign bus.mem_MemRead    = rd_mux;

    // Gating with reset drops a response already in flight when reset lands
    // in the response cycle, not just the one after.
    assign bus.a_rvalid = (resp_own == OWN_A) && !reset;
    assign bus.b_rvalid = (resp_own == OWN_B) && !reset;
    assign bus.a_rdata  = bus.mem_read_data;
    assign bus.b_rdata  = bus.mem_read_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (shadow memory, pending-response owner, denial count).
module tb_dmem_arbiter;

  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Memory: registered read, write committed at the edge, read data held on writes.
  logic [7:0] tmem [256];
  always @(posedge clk) begin
    if (bus.mem_MemWrite) tmem[bus.mem_address] <= bus.mem_write_data;
    else if (bus.mem_MemRead) bus.mem_read_data <= tmem[bus.mem_address];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  logic [7:0] smem [256];
  int         b_denied = 0;
  int         pend = 0;       // 0 none, 1 A, 2 B
  logic [7:0] pend_data = '0;
  bit         model_ok = 0;
  bit         last_ea = 0, last_eb = 0;
  bit         ea, eb, e_we, e_rd;
  logic [7:0] e_addr, e_wd;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      eb = !reset && bus.b_req && (!bus.a_req || b_denied >= int'(MAX_WAIT));
      ea = !reset && bus.a_req && !eb;
      e_addr = '0; e_wd = '0; e_we = 0; e_rd = 0;
      if (eb) begin
        e_addr = bus.b_addr; e_wd = bus.b_wdata; e_we = bus.b_we; e_rd = !bus.b_we;
      end else if (ea) begin
        e_addr = bus.a_addr; e_wd = bus.a_wdata; e_we = bus.a_we; e_rd = !bus.a_we;
      end
      if (model_ok) begin
        chk("a_gnt", bus.a_gnt, ea);
        chk("b_gnt", bus.b_gnt, eb);
        chk("stall", bus.stall, bus.a_req && !ea);
        chk("mem_address", bus.mem_address, e_addr);
        chk("mem_write_data", bus.mem_write_data, e_wd);
        chk("mem_MemWrite", bus.mem_MemWrite, e_we);
        chk("mem_MemRead", bus.mem_MemRead, e_rd);
        chk("a_rvalid", bus.a_rvalid, (pend == 1) && !reset);
        chk("b_rvalid", bus.b_rvalid, (pend == 2) && !reset);
        if (pend == 1 && !reset) chk("a_rdata", bus.a_rdata, pend_data);
        if (pend == 2 && !reset) chk("b_rdata", bus.b_rdata, pend_data);
      end
      if (reset) begin
        b_denied = 0;
        pend = 0;
        model_ok = 1;
      end else begin
        pend = 0;
        if (e_rd) begin
          pend = eb ? 2 : 1;
          pend_data = smem[e_addr];
        end
        if (e_we) smem[e_addr] = e_wd;
        b_denied = (bus.b_req && !eb) ? b_denied + 1 : 0;
      end
      last_ea = ea;
      last_eb = eb;
    end
  end

  task automatic idle();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  task automatic set_a(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tmem[i] = 8'(i * 7 + 3);
      smem[i] = 8'(i * 7 + 3);
    end
    tmem[8'h10] = 8'h5A;
    smem[8'h10] = 8'h5A;
    idle();
    reset = 1;

    @(negedge clk);
    @(negedge clk); #3;
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_memread", bus.mem_MemRead, 0);

    // A read only
    @(negedge clk); reset = 0; set_a(0, 8'h10, 8'h00); #3;
    chk("rdA_gnt", bus.a_gnt, 1);
    chk("rdA_memread", bus.mem_MemRead, 1);
    chk("rdA_addr", bus.mem_address, 8'h10);
    @(negedge clk); idle(); #3;
    chk("rdA_rvalid", bus.a_rvalid, 1);
    chk("rdA_rdata", bus.a_rdata, 8'h5A);
    chk("rdA_b_rvalid", bus.b_rvalid, 0);

    // B write then A read of the same address
    @(negedge clk); set_b(1, 8'h20, 8'h3C); #3;
    chk("wrB_gnt", bus.b_gnt, 1);
    chk("wrB_memwrite", bus.mem_MemWrite, 1);
    @(negedge clk); idle(); set_a(0, 8'h20, 8'h00); #3;
    chk("rdA20_gnt", bus.a_gnt, 1);
    chk("wrB_no_resp", bus.b_rvalid, 0);
    @(negedge clk); idle(); #3;
    chk("rdA20_rvalid", bus.a_rvalid, 1);
    chk("rdA20_rdata", bus.a_rdata, 8'h3C);

    // Continuous conflict
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin set_a(0, 8'h01, 8'h00); set_b(0, 8'h02, 8'h00); end
      if (i == 5) bus.b_req = 0;
      #3;
      if (i < 4) begin
        chk("cfl_a_gnt", bus.a_gnt, 1);
        chk("cfl_b_gnt", bus.b_gnt, 0);
      end else if (i == 4) begin
        chk("cfl_b_win", bus.b_gnt, 1);
        chk("cfl_stall", bus.stall, 1);
        chk("cfl_a_lose", bus.a_gnt, 0);
      end else begin
        chk("cfl_a_again", bus.a_gnt, 1);
        chk("cfl_b_rvalid", bus.b_rvalid, 1);
        chk("cfl_b_rdata", bus.b_rdata, 8'h11);
      end
    end
    @(negedge clk); idle();

    // Reset mid-read
    @(negedge clk); set_a(0, 8'h10, 8'h00); #3;
    chk("rmr_gnt", bus.a_gnt, 1);
    @(negedge clk); idle(); reset = 1; #3;
    chk("rmr_rvalid_in_rst", bus.a_rvalid, 0);
    @(negedge clk); reset = 0; #3;
    chk("rmr_a_rvalid_after", bus.a_rvalid, 0);
    chk("rmr_b_rvalid_after", bus.b_rvalid, 0);

    // Write produces no response
    @(negedge clk); set_a(1, 8'h01, 8'hFF); #3;
    chk("wrA_memwrite", bus.mem_MemWrite, 1);
    @(negedge clk); idle(); #3;
    chk("wrA_no_a_rvalid", bus.a_rvalid, 0);
    chk("wrA_no_b_rvalid", bus.b_rvalid, 0);
    @(negedge clk); set_a(0, 8'h01, 8'h00); #3;
    chk("rdA01_gnt", bus.a_gnt, 1);
    @(negedge clk); idle(); #3;
    chk("rdA01_rvalid", bus.a_rvalid, 1);
    chk("rdA01_rdata", bus.a_rdata, 8'hFF);

    // Random traffic; a denied requester holds its request stable
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 63) == 0);
      if (!(bus.a_req && !last_ea)) begin
        bus.a_req   = ($urandom_range(0, 3) != 0);
        bus.a_we    = ($urandom_range(0, 2) == 0);
        bus.a_addr  = 8'($urandom_range(0, 15));
        bus.a_wdata = 8'($urandom);
      end
      if (!(bus.b_req && !last_eb)) begin
        bus.b_req   = ($urandom_range(0, 2) == 0);
        bus.b_we    = ($urandom_range(0, 1) == 0);
        bus.b_addr  = 8'($urandom_range(0, 15));
        bus.b_wdata = 8'($urandom);
      end
    end
    @(negedge clk); idle(); reset = 0;
    @(negedge clk); #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
